sdram_frame_arb: RTL



---
 rtl/sdram_frame_arb.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sdram_frame_arb.sv
// Burst request arbiter between the camera/display FIFOs and sdram_top: one 512-word burst at a time.
// Define SDRAM_DOUBLE_BUFFER_EN for two-bank ping-pong; otherwise a single bank (bit 22 stays 0).
module sdram_frame_arb #(
    parameter int BURST_LEN    = 512,
    parameter int FRAME_BURSTS = 1440,
    parameter int RD_LOW_WM    = 512
) (
    input  logic        clk_133M_i,
    input  logic        rst_133i,
    input  logic        cam_frame_tog,
    input  logic        vga_frame_tog,
    input  logic [10:0] wr_fifo_used,
    input  logic [10:0] rd_fifo_used,
    output logic        wr_sdram_req,
    input  logic        wr_sdram_ack,
    output logic [23:0] wr_sdram_add,
    output logic        rd_sdram_req,
    input  logic        rd_sdram_ack,
    output logic [23:0] rd_sdram_add,
    output logic [15:0] frame_cnt,
    output logic [7:0]  drop_cnt
);

    localparam logic [12:0] LP_FRAME = 13'(FRAME_BURSTS);
    localparam logic [10:0] LP_BURST = 11'(BURST_LEN);
    localparam logic [10:0] LP_RDWM  = 11'(RD_LOW_WM);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_BUSY = 2'd1,
        ST_RD_BUSY = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cam_sync;
    logic [2:0]  r_vga_sync;
    logic        r_cam_pend;
    logic        r_vga_pend;
    logic        r_first;
    logic [12:0] r_wr_idx;
    logic [12:0] r_rd_idx;
    logic        r_wr_req;
    logic        r_rd_req;
    logic [23:0] r_wr_add;
    logic [23:0] r_rd_add;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_drop_cnt;

    logic        w_cam_evt;
    logic        w_vga_evt;
    logic        w_wr_full;
    logic [12:0] w_wr_idx_eff;
    logic [12:0] w_rd_idx_eff;
    logic        w_wr_elig;
    logic        w_rd_elig;
    logic        w_wr_bank_nxt;
    logic        w_disp_bank_nxt;
    logic        w_rd_bank_nxt;

    always_ff @(posedge clk_133M_i or negedge rst_133i) begin
        if (!rst_133i) begin
            r_cam_sync <= '0;
            r_vga_sync <= '0;
        end else begin
            r_cam_sync <= {r_cam_sync[1:0], cam_frame_tog};
            r_vga_sync <= {r_vga_sync[1:0], vga_frame_tog};
        end
    end

    assign w_cam_evt = r_cam_sync[2] ^ r_cam_sync[1];
    assign w_vga_evt = r_vga_sync[2] ^ r_vga_sync[1];
    assign w_wr_full = (r_wr_idx == LP_FRAME);

    // Pending frame events take effect in the same IDLE cycle as the eligibility check.
    assign w_wr_idx_eff = r_cam_pend ? 13'd0 : r_wr_idx;
    assign w_rd_idx_eff = r_vga_pend ? 13'd0 : r_rd_idx;
    assign w_rd_elig    = (rd_fifo_used <= LP_RDWM) && (w_rd_idx_eff < LP_FRAME);
    assign w_wr_elig    = (wr_fifo_used >= LP_BURST) && (w_wr_idx_eff < LP_FRAME);

`ifdef SDRAM_DOUBLE_BUFFER_EN
    logic r_wr_bank;
    logic r_disp_bank;
    logic r_rd_bank;

    assign w_wr_bank_nxt   = (r_cam_pend && w_wr_full) ? ~r_wr_bank : r_wr_bank;
    assign w_disp_bank_nxt = (r_cam_pend && w_wr_full) ? r_wr_bank : r_disp_bank;
    assign w_rd_bank_nxt   = r_vga_pend ? w_disp_bank_nxt : r_rd_bank;

    always_ff @(posedge clk_133M_i or negedge rst_133i) begin
        if (!rst_133i) begin
            r_wr_bank   <= 1'b0;
            r_disp_bank <= 1'b1;
            r_rd_bank   <= 1'b1;
        end else if (r_state == ST_IDLE) begin
            r_wr_bank   <= w_wr_bank_nxt;
            r_disp_bank <= w_disp_bank_nxt;
            r_rd_bank   <= w_rd_bank_nxt;
        end
    end
`else
    assign w_wr_bank_nxt   = 1'b0;
    assign w_disp_bank_nxt = 1'b0;
    assign w_rd_bank_nxt   = 1'b0;
`endif

    always_ff @(posedge clk_133M_i or negedge rst_133i) begin
        if (!rst_133i) begin
            r_state     <= ST_IDLE;
            r_cam_pend  <= 1'b0;
            r_vga_pend  <= 1'b0;
            r_first     <= 1'b1;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_wr_req    <= 1'b0;
            r_rd_req    <= 1'b0;
            r_wr_add    <= '0;
            r_rd_add    <= '0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_cam_pend <= r_cam_pend | w_cam_evt;
            r_vga_pend <= r_vga_pend | w_vga_evt;
            case (r_state)
                ST_IDLE: begin
                    r_cam_pend <= w_cam_evt;
                    r_vga_pend <= w_vga_evt;
                    if (r_cam_pend) begin
                        r_wr_idx <= '0;
                        r_first  <= 1'b0;
                        // The start-up event before any data is written is not a drop.
                        if (w_wr_full)
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        else if (!(r_first && r_wr_idx == 13'd0) && r_drop_cnt != 8'hFF)
                            r_drop_cnt <= r_drop_cnt + 8'd1;
                    end
                    if (r_vga_pend)
                        r_rd_idx <= '0;
                    if (w_rd_elig) begin
                        r_rd_req <= 1'b1;
                        r_rd_add <= {1'b0, w_rd_bank_nxt, w_rd_idx_eff, 9'd0};
                        r_state  <= ST_RD_BUSY;
                    end else if (w_wr_elig) begin
                        r_wr_req <= 1'b1;
                        r_wr_add <= {1'b0, w_wr_bank_nxt, w_wr_idx_eff, 9'd0};
                        r_state  <= ST_WR_BUSY;
                    end
                end
                ST_WR_BUSY: begin
                    if (wr_sdram_ack) begin
                        r_wr_req <= 1'b0;
                        r_wr_idx <= r_wr_idx + 13'd1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RD_BUSY: begin
                    if (rd_sdram_ack) begin
                        r_rd_req <= 1'b0;
                        r_rd_idx <= r_rd_idx + 13'd1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wr_sdram_req = r_wr_req;
    assign wr_sdram_add = r_wr_add;
    assign rd_sdram_req = r_rd_req;
    assign rd_sdram_add = r_rd_add;
    assign frame_cnt    = r_frame_cnt;
    assign drop_cnt     = r_drop_cnt;

endmodule
